// File: rtl/decode_stage_if.sv
// Fetch-to-execute bundle for the decode stage: instruction in, register-file read/writeback,
// and the decoded payload handed to execute. master = surrounding pipeline, slave = decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic            flush;

    logic [4:0]      rf_ra1;
    logic [4:0]      rf_ra2;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    logic            wb_we;
    logic [4:0]      wb_wa;
    logic [XLEN-1:0] wb_wd;

    logic            ex_ready;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rd;
    logic [2:0]      ex_funct3;
    logic [3:0]      ex_alu_op;
    logic            ex_reg_we;
    logic            ex_is_load;
    logic            ex_is_store;
    logic            ex_is_branch;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic            ex_is_lui;
    logic            ex_is_auipc;
    logic            ex_illegal;

    modport master (
        output if_valid, if_instr, if_pc, flush, rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd, ex_ready,
        input  id_ready, rf_ra1, rf_ra2, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rd, ex_funct3, ex_alu_op, ex_reg_we, ex_is_load, ex_is_store, ex_is_branch,
               ex_is_jal, ex_is_jalr, ex_is_lui, ex_is_auipc, ex_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, flush, rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd, ex_ready,
        output id_ready, rf_ra1, rf_ra2, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
               ex_rd, ex_funct3, ex_alu_op, ex_reg_we, ex_is_load, ex_is_store, ex_is_branch,
               ex_is_jal, ex_is_jalr, ex_is_lui, ex_is_auipc, ex_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: one-cycle registered decode with writeback bypass and load-use stall.
// Holds its output while execute is not ready; flush empties it, rst clears everything.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;

    assign instr  = bus.if_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign bus.rf_ra1 = rs1;
    assign bus.rf_ra2 = rs2;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic            d_lui, d_auipc, d_jal, d_jalr, d_branch, d_load, d_store, d_illegal;
    logic            d_writes;
    logic [XLEN-1:0] d_imm;
    logic [3:0]      d_alu_op;

    always_comb begin
        d_lui     = 1'b0;
        d_auipc   = 1'b0;
        d_jal     = 1'b0;
        d_jalr    = 1'b0;
        d_branch  = 1'b0;
        d_load    = 1'b0;
        d_store   = 1'b0;
        d_illegal = 1'b0;
        d_writes  = 1'b0;
        d_imm     = '0;
        d_alu_op  = 4'b0000;
        case (opcode)
            OPC_LUI:    begin d_lui    = 1'b1; d_writes = 1'b1; d_imm = imm_u; end
            OPC_AUIPC:  begin d_auipc  = 1'b1; d_writes = 1'b1; d_imm = imm_u; end
            OPC_JAL:    begin d_jal    = 1'b1; d_writes = 1'b1; d_imm = imm_j; end
            OPC_JALR:   begin d_jalr   = 1'b1; d_writes = 1'b1; d_imm = imm_i; end
            OPC_BRANCH: begin d_branch = 1'b1;                  d_imm = imm_b; end
            OPC_LOAD:   begin d_load   = 1'b1; d_writes = 1'b1; d_imm = imm_i; end
            OPC_STORE:  begin d_store  = 1'b1;                  d_imm = imm_s; end
            OPC_OPIMM: begin
                d_writes = 1'b1;
                d_imm    = imm_i;
                // shift-immediates carry the arithmetic/logical select in instr[30]
                d_alu_op = (funct3 == 3'b101) ? {instr[30], funct3} : {1'b0, funct3};
            end
            OPC_OP: begin
                d_writes = 1'b1;
                d_alu_op = {instr[30], funct3};
            end
            default:    d_illegal = 1'b1;
        endcase
    end

    logic uses_rs1, uses_rs2;
    assign uses_rs1 = ~(d_lui | d_auipc | d_jal);
    assign uses_rs2 = d_branch | d_store | (opcode == OPC_OP);

    function automatic logic [XLEN-1:0] pick_operand(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_val,
        input logic            we,
        input logic [4:0]      wa,
        input logic [XLEN-1:0] wd
    );
        if (rs == 5'd0)
            return '0;
        else if (we && (wa == rs))
            return wd;
        else
            return rf_val;
    endfunction

    logic [XLEN-1:0] rs1_val, rs2_val;
    assign rs1_val = pick_operand(rs1, bus.rf_rd1, bus.wb_we, bus.wb_wa, bus.wb_wd);
    assign rs2_val = pick_operand(rs2, bus.rf_rd2, bus.wb_we, bus.wb_wa, bus.wb_wd);

    logic hazard, capture;
    assign hazard = bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) &
                    ((uses_rs1 & (bus.ex_rd == rs1)) | (uses_rs2 & (bus.ex_rd == rs2)));
    assign bus.id_ready = (~bus.ex_valid | bus.ex_ready) & ~hazard & ~bus.flush;
    assign capture      = bus.if_valid & bus.id_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ex_valid     <= 1'b0;
            bus.ex_pc        <= '0;
            bus.ex_rs1_val   <= '0;
            bus.ex_rs2_val   <= '0;
            bus.ex_imm       <= '0;
            bus.ex_rd        <= '0;
            bus.ex_funct3    <= '0;
            bus.ex_alu_op    <= '0;
            bus.ex_reg_we    <= 1'b0;
            bus.ex_is_load   <= 1'b0;
            bus.ex_is_store  <= 1'b0;
            bus.ex_is_branch <= 1'b0;
            bus.ex_is_jal    <= 1'b0;
            bus.ex_is_jalr   <= 1'b0;
            bus.ex_is_lui    <= 1'b0;
            bus.ex_is_auipc  <= 1'b0;
            bus.ex_illegal   <= 1'b0;
        end else if (bus.flush) begin
            bus.ex_valid <= 1'b0;
        end else if (capture) begin
            bus.ex_valid     <= 1'b1;
            bus.ex_pc        <= bus.if_pc;
            bus.ex_rs1_val   <= rs1_val;
            bus.ex_rs2_val   <= rs2_val;
            bus.ex_imm       <= d_imm;
            bus.ex_rd        <= rd;
            bus.ex_funct3    <= funct3;
            bus.ex_alu_op    <= d_alu_op;
            bus.ex_reg_we    <= d_writes & (rd != 5'd0);
            bus.ex_is_load   <= d_load;
            bus.ex_is_store  <= d_store;
            bus.ex_is_branch <= d_branch;
            bus.ex_is_jal    <= d_jal;
            bus.ex_is_jalr   <= d_jalr;
            bus.ex_is_lui    <= d_lui;
            bus.ex_is_auipc  <= d_auipc;
            bus.ex_illegal   <= d_illegal;
        end else if (bus.ex_ready) begin
            bus.ex_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random traffic, all checked cycle by
// cycle against a transaction-level model of the decode register.
module tb_decode_stage;
    logic clk;
    logic rst;

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BRANCH = 7'h63;
    localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33;

    // flags = {reg_we, load, store, branch, jal, jalr, lui, auipc, illegal}
    typedef struct {
        logic [31:0] pc, rs1v, rs2v, imm;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [8:0]  flags;
    } ref_t;

    ref_t m;
    logic m_valid;
    logic obs_ready;

    function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'd0;
        if (bus.wb_we && bus.wb_wa == rs) return bus.wb_wd;
        return rf;
    endfunction

    function automatic ref_t ref_decode(input logic [31:0] ins);
        ref_t r;
        logic [6:0]  op = ins[6:0];
        logic [11:0] i_f = ins[31:20];
        logic [11:0] s_f = {ins[31:25], ins[11:7]};
        logic [12:0] b_f = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic [20:0] j_f = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        bit writes;
        r.pc    = bus.if_pc;
        r.rs1v  = ref_operand(ins[19:15], bus.rf_rd1);
        r.rs2v  = ref_operand(ins[24:20], bus.rf_rd2);
        r.rd    = ins[11:7];
        r.f3    = ins[14:12];
        r.alu   = 4'd0;
        r.imm   = 32'd0;
        r.flags = 9'd0;
        writes  = (op == LUI || op == AUIPC || op == JAL || op == JALR ||
                   op == LOAD || op == OPIMM || op == OP);
        if (op == LUI || op == AUIPC)       r.imm = ins & 32'hFFFF_F000;
        else if (op == JAL)                 r.imm = 32'(int'($signed(j_f)));
        else if (op == BRANCH)              r.imm = 32'(int'($signed(b_f)));
        else if (op == STORE)               r.imm = 32'(int'($signed(s_f)));
        else if (op == JALR || op == LOAD || op == OPIMM) r.imm = 32'(int'($signed(i_f)));
        if (op == OP || (op == OPIMM && r.f3 == 3'd5)) r.alu = {ins[30], r.f3};
        else if (op == OPIMM)                           r.alu = {1'b0, r.f3};
        r.flags[8] = writes && (r.rd != 0);
        r.flags[7] = (op == LOAD);
        r.flags[6] = (op == STORE);
        r.flags[5] = (op == BRANCH);
        r.flags[4] = (op == JAL);
        r.flags[3] = (op == JALR);
        r.flags[2] = (op == LUI);
        r.flags[1] = (op == AUIPC);
        r.flags[0] = !(writes || op == BRANCH || op == STORE);
        return r;
    endfunction

    function automatic logic [8:0] dut_flags();
        return {bus.ex_reg_we, bus.ex_is_load, bus.ex_is_store, bus.ex_is_branch, bus.ex_is_jal,
                bus.ex_is_jalr, bus.ex_is_lui, bus.ex_is_auipc, bus.ex_illegal};
    endfunction

    task automatic cmp_regs();
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        chk("ex_pc", bus.ex_pc, m.pc);
        chk("ex_rs1_val", bus.ex_rs1_val, m.rs1v);
        chk("ex_rs2_val", bus.ex_rs2_val, m.rs2v);
        chk("ex_imm", bus.ex_imm, m.imm);
        chk("ex_rd", 32'(bus.ex_rd), 32'(m.rd));
        chk("ex_funct3", 32'(bus.ex_funct3), 32'(m.f3));
        chk("ex_alu_op", 32'(bus.ex_alu_op), 32'(m.alu));
        chk("ex_flags", 32'(dut_flags()), 32'(m.flags));
    endtask

    // Inputs are already set (at the falling edge); check combinational outputs, advance one cycle.
    task automatic step();
        logic [31:0] ins;
        logic [6:0]  op;
        bit use1, use2, hz, rdy;
        #1;
        ins  = bus.if_instr;
        op   = ins[6:0];
        use1 = !(op == LUI || op == AUIPC || op == JAL);
        use2 = (op == BRANCH || op == STORE || op == OP);
        hz   = m_valid && m.flags[7] && m.rd != 0 &&
               ((use1 && m.rd == ins[19:15]) || (use2 && m.rd == ins[24:20]));
        rdy  = (!m_valid || bus.ex_ready) && !hz && !bus.flush;
        chk("rf_ra1", 32'(bus.rf_ra1), 32'(ins[19:15]));
        chk("rf_ra2", 32'(bus.rf_ra2), 32'(ins[24:20]));
        chk("id_ready", 32'(bus.id_ready), 32'(rdy));
        obs_ready = bus.id_ready;
        if (rst) begin
            m_valid = 1'b0;
            m = '{pc: 0, rs1v: 0, rs2v: 0, imm: 0, rd: 0, f3: 0, alu: 0, flags: 0};
        end else if (bus.flush) begin
            m_valid = 1'b0;
        end else if (bus.if_valid && rdy) begin
            m = ref_decode(ins);
            m_valid = 1'b1;
        end else if (bus.ex_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cmp_regs();
    endtask

    task automatic present(input logic [31:0] ins, input logic [31:0] pc, input logic exr);
        bus.if_valid = 1'b1;
        bus.if_instr = ins;
        bus.if_pc    = pc;
        bus.ex_ready = exr;
        bus.flush    = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        logic [6:0] ops [9];
        int k = $urandom_range(0, 9);
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP};
        w[6:0]   = (k < 9) ? ops[k] : 7'($urandom);
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0; bus.flush = 0;
        bus.rf_rd1 = 0; bus.rf_rd2 = 0; bus.wb_we = 0; bus.wb_wa = 0; bus.wb_wd = 0;
        bus.ex_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_valid = 1'b0;
        m = '{pc: 0, rs1v: 0, rs2v: 0, imm: 0, rd: 0, f3: 0, alu: 0, flags: 0};
        cmp_regs();
        rst = 1'b0;

        // addi x5,x0,-1
        present(32'hFFF0_0293, 32'h100, 1'b1);
        bus.rf_rd1 = 32'h1234;
        step();
        chk("addi_valid", 32'(bus.ex_valid), 32'd1);
        chk("addi_imm", bus.ex_imm, 32'hFFFF_FFFF);
        chk("addi_rs1", bus.ex_rs1_val, 32'd0);
        chk("addi_rd_we", {27'd0, bus.ex_reg_we, bus.ex_rd}, {27'd0, 1'b1, 5'd5});

        // add x3,x1,x2 with x2 bypassed from writeback
        present(32'h0020_81B3, 32'h104, 1'b1);
        bus.rf_rd1 = 7; bus.rf_rd2 = 9;
        bus.wb_we = 1; bus.wb_wa = 2; bus.wb_wd = 32'h55;
        step();
        chk("add_rs1", bus.ex_rs1_val, 32'd7);
        chk("add_rs2_bypass", bus.ex_rs2_val, 32'h55);
        chk("add_alu", 32'(bus.ex_alu_op), 32'd0);
        bus.wb_we = 0;

        // lw x6,0(x1) then add x7,x6,x6: one bubble
        present(32'h0000_A303, 32'h108, 1'b1);
        step();
        present(32'h0063_03B3, 32'h10C, 1'b1);
        step();
        chk("lu_stall_ready", 32'(obs_ready), 32'd0);
        chk("lu_bubble", 32'(bus.ex_valid), 32'd0);
        step();
        chk("lu_capture", {27'd0, bus.ex_valid, bus.ex_rd}, {27'd0, 1'b1, 5'd7});

        // sub x4,x1,x2 then 3 cycles of execute back-pressure
        present(32'h4020_8233, 32'h110, 1'b1);
        step();
        chk("sub_alu", 32'(bus.ex_alu_op), 32'b1000);
        present(32'hFFF0_0293, 32'h114, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_ready", 32'(obs_ready), 32'd0);
            chk("stall_pc", bus.ex_pc, 32'h110);
        end
        bus.ex_ready = 1'b1;
        step();
        chk("after_stall_pc", bus.ex_pc, 32'h114);

        // flush beats a valid fetch
        present(32'h0010_0093, 32'h118, 1'b1);
        bus.flush = 1'b1;
        step();
        chk("flush_ready", 32'(obs_ready), 32'd0);
        chk("flush_valid", 32'(bus.ex_valid), 32'd0);

        // unknown opcode
        present(32'h0000_007F, 32'h11C, 1'b1);
        step();
        chk("illegal_flag", 32'(bus.ex_illegal), 32'd1);
        chk("illegal_we", 32'(bus.ex_reg_we), 32'd0);

        // reset in the middle of a stall
        present(32'h0010_0093, 32'h120, 1'b1);
        step();
        present(32'h0020_0113, 32'h124, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_pc", bus.ex_pc, 32'd0);
        rst = 1'b0;
        present(32'h0020_0113, 32'h124, 1'b1);
        step();
        chk("post_rst_capture", bus.ex_pc, 32'h124);

        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom_range(0, 99) < 2);
            bus.if_valid = ($urandom_range(0, 9) < 8);
            bus.if_instr = rand_instr();
            bus.if_pc    = $urandom;
            bus.flush    = ($urandom_range(0, 99) < 8);
            bus.ex_ready = ($urandom_range(0, 3) != 0);
            bus.rf_rd1   = $urandom;
            bus.rf_rd2   = $urandom;
            bus.wb_we    = $urandom_range(0, 1);
            bus.wb_wa    = 5'($urandom_range(0, 3));
            bus.wb_wd    = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 if_valid  in  1  fetch presents an instruction.
REQ-005 if_instr  in  32  RV32I instruction word.
REQ-006 if_pc  in  32  PC of if_instr.
REQ-007 id_ready  out  1  stage accepts if_instr this cycle.
REQ-008 flush  in  1  discard the held instruction (taken branch/jump).
REQ-009 rf_ra1, rf_ra2  out  5  register file read addresses (combinational, = rs1/rs2 fields of if_instr).
REQ-010 rf_rd1, rf_rd2  in  32  register file read data (combinational).
REQ-011 wb_we  in  1, wb_wa  in  5, wb_wd  in  32  writeback port, same signals driven into the register file.
REQ-012 ex_ready  in  1  execute stage consumes ex_* this cycle.
REQ-013 ex_valid  out  1  ex_* hold a valid decoded instruction.
REQ-014 ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  32  registered PC, operands, sign-extended immediate.
REQ-015 ex_rd  out  5; ex_funct3  out  3; ex_alu_op  out  4  registered destination, funct3, ALU selector.
REQ-016 ex_reg_we, ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_is_lui, ex_is_auipc, ex_illegal  out  1  registered decode flags.

Function
REQ-017 Opcodes decoded: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 OP-IMM, 0110011 OP; any other opcode SHALL set ex_illegal=1 with all other flags and ex_reg_we = 0.
REQ-018 Immediates: I/S/B/U/J formats per RV32I, sign-extended from instr[31]; B and J bit0 = 0; U = {instr[31:12],12'b0}; R-type imm = 0.
REQ-019 ex_alu_op = {instr[30], funct3} for OP, and for OP-IMM with funct3=101; {1'b0, funct3} for other OP-IMM; 4'b0000 for all other opcodes.
REQ-020 ex_reg_we = 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and forced 0 when rd = 0.
REQ-021 Operand select per source: rs = 0 -> 0; else wb_we & wb_wa = rs -> wb_wd (bypass); else rf_rdN.
REQ-022 Load-use hazard = ex_valid & ex_is_load & ex_rd != 0 & ex_rd equals a source actually used by if_instr (rs1: all except LUI/AUIPC/JAL; rs2: BRANCH/STORE/OP).
REQ-023 id_ready = (~ex_valid | ex_ready) & ~hazard & ~flush.
REQ-024 Capture: if_valid & id_ready -> all ex_* loaded, ex_valid = 1, one-cycle latency.
REQ-025 Drain: ex_ready & ~capture -> ex_valid = 0 next cycle (bubble); on hazard with ex_ready = 1 exactly one bubble is inserted.
REQ-026 Stall: ex_valid & ~ex_ready -> all ex_* hold unchanged; if_instr is not consumed.
REQ-027 Flush: ex_valid = 0 next cycle, regardless of if_valid, ex_ready or hazard; flush has priority over capture.
REQ-028 ex_* payload SHALL change only on capture; when ex_valid = 0, payload is don't-care to consumers.
REQ-029 Forwarding from execute/memory results is a downstream responsibility; this stage only stalls on load-use.

Reset
REQ-030 While rst = 1 at a clock edge: ex_valid = 0 and every ex_* output = 0; rst has priority over flush and capture.
REQ-031 Reset asserted mid-stall discards the held instruction; first capture is possible on the first edge after rst deasserts.

Verification
REQ-032 addi x5,x0,-1 (0xFFF00293), pc=0x100, ex_ready=1 -> next cycle ex_valid=1, ex_rd=5, ex_imm=0xFFFFFFFF, ex_rs1_val=0, ex_reg_we=1, ex_alu_op=0000.
REQ-033 add x3,x1,x2 with rf_rd1=7, rf_rd2=9, wb_we=1, wb_wa=2, wb_wd=0x55 -> ex_rs1_val=7, ex_rs2_val=0x55, ex_alu_op=0000.
REQ-034 lw x6,0(x1) accepted, then add x7,x6,x6 presented -> id_ready=0 one cycle, ex_valid=0 bubble, add captured the following cycle.
REQ-035 ex_ready=0 for 3 cycles with sub in EX -> ex_* stable, id_ready=0; ex_ready=1 -> next instruction captured.
REQ-036 flush=1 with if_valid=1 -> ex_valid=0 next cycle, id_ready=0 that cycle; opcode 0x0000007F -> ex_illegal=1, ex_reg_we=0.
REQ-037 rst=1 while ex_valid=1 and ex_ready=0 -> next cycle ex_valid=0, all ex_* = 0.
